ethernet_reply_frame_streamer: RTL and testbench

Generalised successor of the fixed-size ARP reply builder. It captures a reply header of configurable length (up to MAX_HEAD_BYTES) and its precomputed FCS. It prepends preamble/SFD, optionally zero-pads to the Ethernet minimum, and appends the FCS. The frame is streamed as DATA_W-bit AXI-Stream beats with tkeep/tlast and back-pressure. It sits between the reply CRC engine and the 64-bit serial TX path, and serves ARP, ICMP and UDP replies.

---
 rtl/ethernet_reply_frame_streamer.sv | 165 ++++++++++++++++
 tb/tb_ethernet_reply_frame_streamer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_reply_frame_streamer.sv
// Reply frame streamer: captures a variable-length header plus FCS and streams
// preamble/SFD, header, optional zero pad and FCS as AXI-Stream beats.
module ethernet_reply_frame_streamer #(
   parameter int          DATA_W         = 64,
   parameter int          MAX_HEAD_BYTES = 42,
   parameter int          PAD_EN         = 1,
   parameter int          MIN_HEAD_BYTES = 60,
   parameter logic [63:0] PREAMBLE       = 64'h55555555555555D5
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_crc_valid,
   input  logic [31:0]                 i_crc,
   input  logic [MAX_HEAD_BYTES*8-1:0] i_head,
   input  logic [7:0]                  i_head_len,
   output logic [DATA_W-1:0]           o_tdata,
   output logic [DATA_W/8-1:0]         o_tkeep,
   output logic                        o_tvalid,
   output logic                        o_tlast,
   input  logic                        i_tready,
   output logic                        o_busy,
   output logic                        o_overflow,
   output logic                        o_len_err
);

   localparam int BYTES = DATA_W / 8;
   localparam int HW    = MAX_HEAD_BYTES * 8;
   localparam int MAXP  = (MAX_HEAD_BYTES > MIN_HEAD_BYTES) ? MAX_HEAD_BYTES : MIN_HEAD_BYTES;
   localparam int MAXNB = (12 + MAXP + BYTES - 1) / BYTES;
   localparam int BW    = $clog2(MAXNB + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t            state_q;
   logic [31:0]       crc_q;
   logic [HW-1:0]     head_q;
   logic [7:0]        len_q;
   logic [15:0]       plen_q, flen_q;
   logic [BW-1:0]     nb_q, beat_q;
   logic [BYTES-1:0]  keep_last_q;
   logic [DATA_W-1:0] tdata_q, tdata_d;
   logic [BYTES-1:0]  tkeep_q, tkeep_d;
   logic              tvalid_q, tlast_q, tlast_d, busy_q, ovf_q, len_err_q;

   logic              len_ok;
   logic [15:0]       plen_d, flen_d, rem_d;
   logic [BW-1:0]     nb_d, nxt_beat;
   logic [BYTES-1:0]  keep_last_d;
   logic [15:0]       base;

   assign len_ok = (i_head_len != 8'd0) && (16'(i_head_len) <= 16'(MAX_HEAD_BYTES));

   assign plen_d      = ((PAD_EN != 0) && (16'(len_q) < 16'(MIN_HEAD_BYTES))) ?
                        16'(MIN_HEAD_BYTES) : 16'(len_q);
   assign flen_d      = plen_d + 16'd12;
   assign nb_d        = BW'((flen_d + 16'(BYTES - 1)) / 16'(BYTES));
   assign rem_d       = flen_d % 16'(BYTES);
   assign keep_last_d = (rem_d == 16'd0) ? {BYTES{1'b1}} : ~({BYTES{1'b1}} >> rem_d);

   // Byte k of the whole frame, from the captured request and computed lengths.
   function automatic logic [7:0] frame_byte(input logic [15:0] k);
      logic [HW-1:0] hsh;
      logic [31:0]   csh;
      logic [15:0]   ci;
      ci  = k - 16'd8 - plen_q;
      hsh = head_q << {k - 16'd8, 3'b000};
      csh = crc_q << {ci, 3'b000};
      frame_byte = 8'h00;
      if (k < 16'd8)                       frame_byte = PREAMBLE[{~k[2:0], 3'b000} +: 8];
      else if (k < 16'd8 + 16'(len_q))     frame_byte = hsh[HW-1 -: 8];
      else if (k < 16'd8 + plen_q)         frame_byte = 8'h00;
      else if (k < flen_q)                 frame_byte = csh[31:24];
   endfunction

   assign nxt_beat = tvalid_q ? beat_q + 1'b1 : '0;

   always_comb begin
      tdata_d = '0;
      base    = 16'(nxt_beat) * 16'(BYTES);
      for (int j = 0; j < BYTES; j++)
         tdata_d[(BYTES-1-j)*8 +: 8] = frame_byte(base + 16'(j));
      tlast_d = (nxt_beat == nb_q - 1'b1);
      tkeep_d = tlast_d ? keep_last_q : {BYTES{1'b1}};
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= IDLE;
         crc_q       <= '0;
         head_q      <= '0;
         len_q       <= '0;
         plen_q      <= '0;
         flen_q      <= '0;
         nb_q        <= '0;
         beat_q      <= '0;
         keep_last_q <= '0;
         tdata_q     <= '0;
         tkeep_q     <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
         len_err_q   <= 1'b0;
      end else begin
         ovf_q     <= 1'b0;
         len_err_q <= 1'b0;
         case (state_q)
            IDLE: if (i_crc_valid) begin
               crc_q     <= i_crc;
               head_q    <= i_head;
               len_q     <= len_ok ? i_head_len : 8'(MAX_HEAD_BYTES);
               len_err_q <= ~len_ok;
               busy_q    <= 1'b1;
               state_q   <= LOAD;
            end
            LOAD: begin
               ovf_q       <= i_crc_valid;
               plen_q      <= plen_d;
               flen_q      <= flen_d;
               nb_q        <= nb_d;
               keep_last_q <= keep_last_d;
               state_q     <= SEND;
            end
            SEND: begin
               ovf_q <= i_crc_valid;
               // First SEND cycle primes beat 0; afterwards beats advance on acceptance.
               if (!tvalid_q || i_tready) begin
                  if (tvalid_q && tlast_q) begin
                     state_q     <= IDLE;
                     crc_q       <= '0;
                     head_q      <= '0;
                     len_q       <= '0;
                     plen_q      <= '0;
                     flen_q      <= '0;
                     nb_q        <= '0;
                     beat_q      <= '0;
                     keep_last_q <= '0;
                     tdata_q     <= '0;
                     tkeep_q     <= '0;
                     tvalid_q    <= 1'b0;
                     tlast_q     <= 1'b0;
                     busy_q      <= 1'b0;
                  end else begin
                     beat_q   <= nxt_beat;
                     tdata_q  <= tdata_d;
                     tkeep_q  <= tkeep_d;
                     tlast_q  <= tlast_d;
                     tvalid_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_tdata    = tdata_q;
   assign o_tkeep    = tkeep_q;
   assign o_tvalid   = tvalid_q;
   assign o_tlast    = tlast_q;
   assign o_busy     = busy_q;
   assign o_overflow = ovf_q;
   assign o_len_err  = len_err_q;

endmodule

// File: tb/tb_ethernet_reply_frame_streamer.sv
// Bench for the reply frame streamer: three builds (64-bit padded, 64-bit unpadded,
// 32-bit padded) checked against a byte-list frame model through beat scoreboards.
module tb_ethernet_reply_frame_streamer;

   typedef struct {
      logic [127:0] data;
      logic [15:0]  keep;
      logic         last;
   } beat_t;

   typedef struct {
      logic [7:0] len;
      int         nb_a;
      logic [7:0] kl_a;
      int         nb_b;
      logic [7:0] kl_b;
      int         nb_c;
      logic       err;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   cv;
   logic [31:0]  crc;
   logic [335:0] head;
   logic [7:0]   hlen;
   logic         tready;

   logic [63:0]  tdata_a, tdata_b;
   logic [31:0]  tdata_c;
   logic [7:0]   tkeep_a, tkeep_b;
   logic [3:0]   tkeep_c;
   logic         tvalid_a, tvalid_b, tvalid_c, tlast_a, tlast_b, tlast_c;
   logic         busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c, lerr_a, lerr_b, lerr_c;

   always #5 clk = ~clk;

   ethernet_reply_frame_streamer u_a (
      .i_clk(clk), .i_reset(rst), .i_crc_valid(cv[0]), .i_crc(crc), .i_head(head),
      .i_head_len(hlen), .o_tdata(tdata_a), .o_tkeep(tkeep_a), .o_tvalid(tvalid_a),
      .o_tlast(tlast_a), .i_tready(tready), .o_busy(busy_a), .o_overflow(ovf_a),
      .o_len_err(lerr_a));

   ethernet_reply_frame_streamer #(.PAD_EN(0)) u_b (
      .i_clk(clk), .i_reset(rst), .i_crc_valid(cv[1]), .i_crc(crc), .i_head(head),
      .i_head_len(hlen), .o_tdata(tdata_b), .o_tkeep(tkeep_b), .o_tvalid(tvalid_b),
      .o_tlast(tlast_b), .i_tready(tready), .o_busy(busy_b), .o_overflow(ovf_b),
      .o_len_err(lerr_b));

   ethernet_reply_frame_streamer #(.DATA_W(32)) u_c (
      .i_clk(clk), .i_reset(rst), .i_crc_valid(cv[2]), .i_crc(crc), .i_head(head),
      .i_head_len(hlen), .o_tdata(tdata_c), .o_tkeep(tkeep_c), .o_tvalid(tvalid_c),
      .o_tlast(tlast_c), .i_tready(tready), .o_busy(busy_c), .o_overflow(ovf_c),
      .o_len_err(lerr_c));

   logic [127:0] m_data [3];
   logic [15:0]  m_keep [3];
   logic         m_valid [3];
   logic         m_last [3];
   logic         m_busy [3];

   assign m_data[0] = {64'd0, tdata_a};
   assign m_data[1] = {64'd0, tdata_b};
   assign m_data[2] = {96'd0, tdata_c};
   assign m_keep[0] = {8'd0, tkeep_a};
   assign m_keep[1] = {8'd0, tkeep_b};
   assign m_keep[2] = {12'd0, tkeep_c};
   assign m_valid[0] = tvalid_a;
   assign m_valid[1] = tvalid_b;
   assign m_valid[2] = tvalid_c;
   assign m_last[0] = tlast_a;
   assign m_last[1] = tlast_b;
   assign m_last[2] = tlast_c;
   assign m_busy[0] = busy_a;
   assign m_busy[1] = busy_b;
   assign m_busy[2] = busy_c;

   beat_t        q0[$], q1[$], q2[$];
   int           n_chk, n_fail;
   int           beats [3];
   logic [15:0]  lastkeep [3];
   logic         stall_prev [3];
   logic [127:0] pdata [3];
   logic [15:0]  pkeep [3];
   logic         plast [3];
   logic         busy_chk [3];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Expected frame as a plain byte list, then cut into beats.
   task automatic push_frame(input int inst, input logic [335:0] h, input logic [7:0] l,
                             input logic [31:0] c);
      logic [7:0] fb[$];
      int         eff, bytes;
      beat_t      bt;
      eff   = (l == 8'd0 || l > 8'd42) ? 42 : int'(l);
      bytes = (inst == 2) ? 4 : 8;
      fb    = {};
      for (int i = 0; i < 7; i++) fb.push_back(8'h55);
      fb.push_back(8'hD5);
      for (int i = 0; i < eff; i++) fb.push_back(h[(41-i)*8 +: 8]);
      if (inst != 1) while (fb.size() < 68) fb.push_back(8'h00);
      for (int i = 3; i >= 0; i--) fb.push_back(c[i*8 +: 8]);
      for (int b = 0; b * bytes < fb.size(); b++) begin
         bt.data = '0;
         bt.keep = '0;
         for (int j = 0; j < bytes; j++)
            if (b * bytes + j < fb.size()) begin
               bt.data[(bytes-1-j)*8 +: 8] = fb[b*bytes+j];
               bt.keep[bytes-1-j] = 1'b1;
            end
         bt.last = ((b + 1) * bytes >= fb.size());
         case (inst)
            0:       q0.push_back(bt);
            1:       q1.push_back(bt);
            default: q2.push_back(bt);
         endcase
      end
   endtask

   task automatic monitor();
      beat_t e;
      logic  have;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (busy_chk[i]) begin
               chk($sformatf("busy_fall%0d", i), 128'(m_busy[i]), 128'd0);
               busy_chk[i] = 1'b0;
            end
            if (stall_prev[i] && !rst) begin
               chk($sformatf("hold_valid%0d", i), 128'(m_valid[i]), 128'd1);
               chk($sformatf("hold_data%0d", i), m_data[i], pdata[i]);
               chk($sformatf("hold_keep%0d", i), 128'(m_keep[i]), 128'(pkeep[i]));
               chk($sformatf("hold_last%0d", i), 128'(m_last[i]), 128'(plast[i]));
            end
            if (m_valid[i] && tready) begin
               have = 1'b0;
               case (i)
                  0:       begin have = (q0.size() > 0); if (have) e = q0.pop_front(); end
                  1:       begin have = (q1.size() > 0); if (have) e = q1.pop_front(); end
                  default: begin have = (q2.size() > 0); if (have) e = q2.pop_front(); end
               endcase
               if (!have) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL beat%0d: got unexpected beat %h, expected none", i, m_data[i]);
               end else begin
                  chk($sformatf("data%0d", i), m_data[i], e.data);
                  chk($sformatf("keep%0d", i), 128'(m_keep[i]), 128'(e.keep));
                  chk($sformatf("last%0d", i), 128'(m_last[i]), 128'(e.last));
               end
               beats[i]++;
               if (m_last[i]) begin
                  lastkeep[i] = m_keep[i];
                  busy_chk[i] = 1'b1;
               end
            end
            stall_prev[i] = m_valid[i] && !tready;
            pdata[i] = m_data[i];
            pkeep[i] = m_keep[i];
            plast[i] = m_last[i];
         end
      end
   endtask

   task automatic randomize_req();
      for (int i = 0; i < 42; i++) head[i*8 +: 8] = 8'($urandom);
      crc = $urandom;
   endtask

   task automatic strobe(input logic [2:0] m, input logic [2:0] push, input logic [7:0] l);
      hlen = l;
      for (int i = 0; i < 3; i++) if (push[i]) push_frame(i, head, l, crc);
      cv = m;
      @(posedge clk); #1;
      cv = 3'b000;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy_a || busy_b || busy_c || q0.size() > 0 || q1.size() > 0 || q2.size() > 0)
             && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout: got busy after %0d cycles, expected idle", t);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_sig(input int which, input string nm);
      int t;
      t = 0;
      while (!((which == 0) ? tvalid_a : tlast_a) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: got no event in %0d cycles, expected event", nm, t);
      end
   endtask

   vec_t tv [8];
   int   snap [3];
   int   t;

   initial begin
      tv[0] = '{8'd42,  9, 8'hFF, 7, 8'hFC, 18, 1'b0};
      tv[1] = '{8'd14,  9, 8'hFF, 4, 8'hC0, 18, 1'b0};
      tv[2] = '{8'd41,  9, 8'hFF, 7, 8'hF8, 18, 1'b0};
      tv[3] = '{8'd0,   9, 8'hFF, 7, 8'hFC, 18, 1'b1};
      tv[4] = '{8'd200, 9, 8'hFF, 7, 8'hFC, 18, 1'b1};
      tv[5] = '{8'd1,   9, 8'hFF, 2, 8'hF8, 18, 1'b0};
      tv[6] = '{8'd43,  9, 8'hFF, 7, 8'hFC, 18, 1'b1};
      tv[7] = '{8'd20,  9, 8'hFF, 4, 8'hFF, 18, 1'b0};

      n_chk = 0;
      n_fail = 0;
      for (int i = 0; i < 3; i++) begin
         beats[i] = 0; lastkeep[i] = '0; stall_prev[i] = 1'b0;
         pdata[i] = '0; pkeep[i] = '0; plast[i] = 1'b0; busy_chk[i] = 1'b0;
      end
      rst = 1'b1; cv = 3'b000; tready = 1'b1; head = '0; hlen = '0; crc = '0;
      fork monitor(); join_none

      #3;
      chk("rst_tvalid", 128'({tvalid_a, tvalid_b, tvalid_c}), 128'd0);
      chk("rst_busy", 128'({busy_a, busy_b, busy_c}), 128'd0);
      chk("rst_data", {tdata_a, tdata_b}, 128'd0);
      chk("rst_flags", 128'({tlast_a, ovf_a, lerr_a, tkeep_a}), 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Table of lengths run on all three builds at once with free-flowing tready.
      for (int v = 0; v < 8; v++) begin
         randomize_req();
         for (int i = 0; i < 3; i++) snap[i] = beats[i];
         strobe(3'b111, 3'b111, tv[v].len);
         @(negedge clk);
         chk($sformatf("len_err_a[%0d]", v), 128'(lerr_a), 128'(tv[v].err));
         chk($sformatf("len_err_b[%0d]", v), 128'(lerr_b), 128'(tv[v].err));
         chk($sformatf("len_err_c[%0d]", v), 128'(lerr_c), 128'(tv[v].err));
         chk($sformatf("busy_rise[%0d]", v), 128'(busy_a), 128'd1);
         chk($sformatf("lat0[%0d]", v), 128'(tvalid_a), 128'd0);
         @(negedge clk);
         chk($sformatf("lat1[%0d]", v), 128'(tvalid_a), 128'd0);
         chk($sformatf("len_err_pulse[%0d]", v), 128'(lerr_a), 128'd0);
         @(negedge clk);
         chk($sformatf("lat2[%0d]", v), 128'(tvalid_a), 128'd1);
         wait_idle();
         chk($sformatf("nb_a[%0d]", v), 128'(beats[0] - snap[0]), 128'(tv[v].nb_a));
         chk($sformatf("nb_b[%0d]", v), 128'(beats[1] - snap[1]), 128'(tv[v].nb_b));
         chk($sformatf("nb_c[%0d]", v), 128'(beats[2] - snap[2]), 128'(tv[v].nb_c));
         chk($sformatf("kl_a[%0d]", v), 128'(lastkeep[0]), 128'(tv[v].kl_a));
         chk($sformatf("kl_b[%0d]", v), 128'(lastkeep[1]), 128'(tv[v].kl_b));
         chk($sformatf("kl_c[%0d]", v), 128'(lastkeep[2]), 128'h0F);
      end

      // Back-pressure with tready pattern 1,0,0,1.
      randomize_req();
      strobe(3'b111, 3'b111, 8'd42);
      t = 0;
      while ((busy_a || busy_b || busy_c) && t < 500) begin
         tready = (t % 4 == 0) || (t % 4 == 3);
         @(posedge clk); #1;
         t++;
      end
      tready = 1'b1;
      wait_idle();

      // Overflow during SEND and in the last-accept cycle, then an immediate next frame.
      randomize_req();
      strobe(3'b001, 3'b001, 8'd42);
      wait_sig(0, "send_start");
      randomize_req();
      cv = 3'b001;
      @(posedge clk); #1;
      cv = 3'b000;
      @(negedge clk);
      chk("ovf_send", 128'(ovf_a), 128'd1);
      @(negedge clk);
      chk("ovf_pulse", 128'(ovf_a), 128'd0);
      wait_sig(1, "last_beat");
      randomize_req();
      cv = 3'b001;
      @(posedge clk); #1;
      randomize_req();
      push_frame(0, head, 8'd42, crc);
      hlen = 8'd42;
      cv = 3'b001;
      @(negedge clk);
      chk("ovf_last", 128'(ovf_a), 128'd1);
      chk("idle_gap", 128'(busy_a), 128'd0);
      @(posedge clk); #1;
      cv = 3'b000;
      @(negedge clk);
      chk("ovf_last_pulse", 128'(ovf_a), 128'd0);
      chk("second_busy", 128'(busy_a), 128'd1);
      wait_idle();

      // Reset while beat 4 is on the bus.
      randomize_req();
      snap[0] = beats[0];
      strobe(3'b001, 3'b001, 8'd42);
      t = 0;
      while (beats[0] - snap[0] < 4 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      chk("beat4_valid", 128'(tvalid_a), 128'd1);
      rst = 1'b1;
      #1;
      chk("arst_tvalid", 128'(tvalid_a), 128'd0);
      chk("arst_busy", 128'(busy_a), 128'd0);
      chk("arst_data", 128'(tdata_a), 128'd0);
      chk("arst_last", 128'(tlast_a), 128'd0);
      q0.delete();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      randomize_req();
      snap[0] = beats[0];
      strobe(3'b001, 3'b001, 8'd42);
      wait_idle();
      chk("post_rst_beats", 128'(beats[0] - snap[0]), 128'd9);

      chk("sb_empty", 128'(q0.size() + q1.size() + q2.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
